// File: rtl/power_emu_run_ctrl.sv
// power_emu_run_ctrl: window run sequencer for the power-emulator adder tree (start/wait/CPA/accumulate/irq)
// Ports: clk, reset (async, active-high); s_read/s_write/s_addr/s_wdata/s_rdata host register bus
// (s_rdata valid one cycle after s_read); dp_start/dp_en/dp_done/dp_vs/dp_vc datapath handshake;
// irq = done & irq_en, registered.
module power_emu_run_ctrl #(
  parameter int BITS = 32,
  parameter int CGES = 13,
  parameter int CHUNK = 9,
  parameter int TIMEOUT = 1024,
  localparam int MAX = $clog2(CGES) + BITS,
  localparam int ACCW = MAX + 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_read,
  input  logic           s_write,
  input  logic [3:0]     s_addr,
  input  logic [31:0]    s_wdata,
  output logic [31:0]    s_rdata,
  output logic           dp_start,
  output logic           dp_en,
  input  logic           dp_done,
  input  logic [MAX-1:0] dp_vs,
  input  logic [MAX-1:0] dp_vc,
  output logic           irq
);
  localparam int NCH = (MAX + CHUNK - 1) / CHUNK;
  localparam int W = NCH * CHUNK;
  localparam int KW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT, SUM, ACC, DONE} state_t;
  state_t state;
  logic [ACCW-1:0] acc;
  logic [MAX-1:0] last;
  logic [W-1:0] vs_r, vc_r, sum_r;
  logic [KW-1:0] k;
  logic cy, irq_en, done, tout;
  logic [7:0] nwin, wins;
  logic [TW-1:0] timer;
  logic [CHUNK:0] csum;
  logic [31:0] rdata;
  logic wr_ctrl, wr_stat, go, abort, busy;
  logic [7:0] nwin_eff, wins_inc;
  logic unused_wdata;
  assign busy = state != IDLE;
  assign wr_ctrl = s_write && s_addr == 4'd0;
  assign wr_stat = s_write && s_addr == 4'd1;
  assign go = wr_ctrl && s_wdata[0];
  assign abort = wr_ctrl && s_wdata[1];
  assign nwin_eff = nwin == 8'd0 ? 8'd1 : nwin;
  assign wins_inc = wins == 8'hFF ? wins : wins + 8'd1;
  assign unused_wdata = ^s_wdata[31:8];
  // one CHUNK-wide slice of the carry-propagate add per SUM cycle, carry held in cy
  assign csum = {1'b0, vs_r[k*CHUNK +: CHUNK]} + {1'b0, vc_r[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, cy};
  always_comb begin
    rdata = '0;
    case (s_addr)
      4'd0: rdata = {29'd0, irq_en, 2'd0};
      4'd1: rdata = {16'd0, wins, 5'd0, tout, done, busy};
      4'd2: rdata = {24'd0, nwin};
      4'd3: rdata = acc[31:0];
      4'd4: rdata = 32'(acc[ACCW-1:32]);
      4'd5: rdata = last[31:0];
      4'd6: rdata = 32'(last[MAX-1:32]);
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s_rdata <= '0;
      dp_start <= 1'b0;
      dp_en <= 1'b0;
      irq <= 1'b0;
      acc <= '0;
      last <= '0;
      vs_r <= '0;
      vc_r <= '0;
      sum_r <= '0;
      k <= '0;
      cy <= 1'b0;
      irq_en <= 1'b0;
      done <= 1'b0;
      tout <= 1'b0;
      nwin <= '0;
      wins <= '0;
      timer <= '0;
    end else begin
      dp_start <= 1'b0;
      irq <= done && irq_en;
      s_rdata <= s_read ? rdata : '0;
      if (wr_ctrl) irq_en <= s_wdata[2];
      if (wr_stat && s_wdata[1]) done <= 1'b0;
      if (wr_stat && s_wdata[2]) tout <= 1'b0;
      if (s_write && s_addr == 4'd2 && !busy) nwin <= s_wdata[7:0];
      if (abort && busy) begin
        state <= IDLE;
        dp_en <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go && !abort) begin
            acc <= '0;
            wins <= '0;
            done <= 1'b0;
            tout <= 1'b0;
            dp_start <= 1'b1;
            state <= START;
          end
          START: begin
            timer <= '0;
            dp_en <= 1'b1;
            state <= WAIT;
          end
          WAIT: if (dp_done) begin
            vs_r <= W'(dp_vs);
            vc_r <= W'(dp_vc);
            k <= '0;
            cy <= 1'b0;
            dp_en <= 1'b0;
            state <= SUM;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            tout <= 1'b1;
            dp_en <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
          SUM: begin
            sum_r[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
            cy <= csum[CHUNK];
            k <= k + 1'b1;
            if (k == KW'(NCH - 1)) state <= ACC;
          end
          ACC: begin
            last <= sum_r[MAX-1:0];
            acc <= acc + ACCW'(sum_r[MAX-1:0]);
            wins <= wins_inc;
            if (wins_inc == nwin_eff) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              dp_start <= 1'b1;
              state <= START;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
